// File: rtl/pmod_spi_adc_reader_pkg.sv
// Shared definitions for the PMOD SPI ADC reader: FSM state type, the
// ADC081S021 default profile and a counter-width helper.
package pmod_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_CS_HOLD  = 3'd3,
    ST_GAP      = 3'd4
  } state_t;

  localparam int unsigned ADC081_SCK_HALF    = 8;
  localparam int unsigned ADC081_FRAME_BITS  = 16;
  localparam int unsigned ADC081_DATA_MSB    = 12;
  localparam int unsigned ADC081_DATA_LSB    = 5;
  localparam int unsigned ADC081_IDLE_CYCLES = 256;

  // Bits needed to hold values 0..maxval, never less than one.
  function automatic int unsigned cnt_width(input int unsigned maxval);
    return (maxval < 2) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/pmod_tick_counter.sv
// Loadable down-counter; done is high while the count sits at zero.
module pmod_tick_counter #(
  parameter int unsigned           WIDTH     = 8,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RESET_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/pmod_spi_adc_reader.sv
// SPI mode-3 read-only master: frames CS/SCK, shifts in FRAME_BITS from sdo,
// and publishes the raw frame plus an extracted field with a valid strobe.
module pmod_spi_adc_reader
  import pmod_pkg::*;
#(
  parameter int unsigned SCK_HALF    = ADC081_SCK_HALF,
  parameter int unsigned FRAME_BITS  = ADC081_FRAME_BITS,
  parameter int unsigned DATA_MSB    = ADC081_DATA_MSB,
  parameter int unsigned DATA_LSB    = ADC081_DATA_LSB,
  parameter int unsigned IDLE_CYCLES = ADC081_IDLE_CYCLES,
  parameter bit          CONTINUOUS  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     cs,
  output logic                     sck,
  input  logic                     sdo,
  output logic [FRAME_BITS-1:0]    frame,
  output logic [DATA_MSB-DATA_LSB:0] data,
  output logic                     valid
);

  localparam int unsigned TMAX = (IDLE_CYCLES > SCK_HALF) ? IDLE_CYCLES - 1 : SCK_HALF - 1;
  localparam int unsigned TW   = cnt_width(TMAX);
  localparam int unsigned BW   = cnt_width(FRAME_BITS - 1);

  localparam logic [TW-1:0] HALF_LOAD = TW'(SCK_HALF - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(IDLE_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LOAD  = BW'(FRAME_BITS - 1);
  // Free-running mode leaves reset already inside a full-length gap.
  localparam logic [TW-1:0] TMR_RST   = CONTINUOUS ? GAP_LOAD : '0;

  state_t                state;
  logic                  pending;
  logic [FRAME_BITS-1:0] shreg;

  logic          tmr_done, tmr_load, tmr_en;
  logic [TW-1:0] tmr_val;
  logic          bit_done, bit_load, bit_dec;

  // Every phase end reloads the timer; only CS_HOLD hands over to the gap.
  always_comb begin
    tmr_load = ((state != ST_IDLE) && tmr_done) || ((state == ST_IDLE) && start);
    tmr_val  = (state == ST_CS_HOLD) ? GAP_LOAD : HALF_LOAD;
    tmr_en   = (state != ST_IDLE);
    bit_load = (state == ST_CS_SETUP) && tmr_done;
    bit_dec  = (state == ST_SHIFT) && sck && tmr_done;
  end

  pmod_tick_counter #(
    .WIDTH     (TW),
    .RESET_VAL (TMR_RST)
  ) u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .done     (tmr_done)
  );

  pmod_tick_counter #(
    .WIDTH     (BW),
    .RESET_VAL ('0)
  ) u_bits (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (bit_load),
    .load_val (BIT_LOAD),
    .en       (bit_dec),
    .done     (bit_done)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CONTINUOUS ? ST_GAP : ST_IDLE;
      cs      <= 1'b1;
      sck     <= 1'b1;
      shreg   <= '0;
      frame   <= '0;
      data    <= '0;
      valid   <= 1'b0;
      pending <= 1'b0;
    end else begin
      valid <= 1'b0;
      // A start landing on the gap's final cycle is consumed by the exit below.
      if (!CONTINUOUS && start && (state != ST_IDLE) && !((state == ST_GAP) && tmr_done))
        pending <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_CS_SETUP;
            cs    <= 1'b0;
          end
        end
        ST_CS_SETUP: begin
          if (tmr_done) begin
            state <= ST_SHIFT;
            sck   <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (tmr_done) begin
            if (!sck) begin
              sck   <= 1'b1;
              shreg <= {shreg[FRAME_BITS-2:0], sdo};
            end else if (bit_done) begin
              state <= ST_CS_HOLD;
            end else begin
              sck <= 1'b0;
            end
          end
        end
        ST_CS_HOLD: begin
          if (tmr_done) begin
            state <= ST_GAP;
            cs    <= 1'b1;
            frame <= shreg;
            data  <= shreg[DATA_MSB:DATA_LSB];
            valid <= 1'b1;
          end
        end
        ST_GAP: begin
          if (tmr_done) begin
            if (CONTINUOUS || pending || start) begin
              state   <= ST_CS_SETUP;
              cs      <= 1'b0;
              pending <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          cs    <= 1'b1;
          sck   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmod_spi_adc_reader.sv
// Bench for pmod_spi_adc_reader: one-shot default, free-running default and a
// small parameter variant, each fed by a behavioural sensor model.
module tb_pmod_spi_adc_reader;

  logic clk;
  int total = 0;
  int bad   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- one-shot default instance ----------------
  logic rst_n_d, start_d, busy_d, cs_d, sck_d, sdo_d, valid_d;
  logic [15:0] frame_d;
  logic [7:0]  data_d;

  pmod_spi_adc_reader #(.CONTINUOUS(1'b0)) u_d (
    .clk(clk), .rst_n(rst_n_d), .start(start_d), .busy(busy_d), .cs(cs_d),
    .sck(sck_d), .sdo(sdo_d), .frame(frame_d), .data(data_d), .valid(valid_d));

  // ---------------- free-running default instance ----------------
  logic rst_n_c, start_c, busy_c, cs_c, sck_c, sdo_c, valid_c;
  logic [15:0] frame_c;
  logic [7:0]  data_c;

  pmod_spi_adc_reader #(.CONTINUOUS(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n_c), .start(start_c), .busy(busy_c), .cs(cs_c),
    .sck(sck_c), .sdo(sdo_c), .frame(frame_c), .data(data_c), .valid(valid_c));

  // ---------------- parameter variant ----------------
  logic rst_n_v, start_v, busy_v, cs_v, sck_v, sdo_v, valid_v;
  logic [11:0] frame_v;
  logic [11:0] data_v;

  pmod_spi_adc_reader #(.SCK_HALF(2), .FRAME_BITS(12), .DATA_MSB(11), .DATA_LSB(0),
                        .IDLE_CYCLES(4), .CONTINUOUS(1'b0)) u_v (
    .clk(clk), .rst_n(rst_n_v), .start(start_v), .busy(busy_v), .cs(cs_v),
    .sck(sck_v), .sdo(sdo_v), .frame(frame_v), .data(data_v), .valid(valid_v));

  // Sensor models: each CS-low window takes the next queued word and presents
  // it MSB first, one bit per falling SCK edge.
  logic [31:0] wq_d[$], wq_c[$], wq_v[$];
  logic [31:0] cur_d, cur_c, cur_v;
  int idx_d, idx_c, idx_v;

  initial begin
    sdo_d = 1'b0; sdo_c = 1'b0; sdo_v = 1'b0;
    idx_d = 0; idx_c = 0; idx_v = 0;
    cur_d = '0; cur_c = '0; cur_v = '0;
  end

  always @(negedge cs_d) begin cur_d = (wq_d.size() > 0) ? wq_d.pop_front() : 32'd0; idx_d = 16; end
  always @(negedge sck_d) if (cs_d === 1'b0 && idx_d > 0) begin idx_d--; sdo_d = cur_d[idx_d]; end
  always @(negedge cs_c) begin cur_c = (wq_c.size() > 0) ? wq_c.pop_front() : 32'd0; idx_c = 16; end
  always @(negedge sck_c) if (cs_c === 1'b0 && idx_c > 0) begin idx_c--; sdo_c = cur_c[idx_c]; end
  always @(negedge cs_v) begin cur_v = (wq_v.size() > 0) ? wq_v.pop_front() : 32'd0; idx_v = 12; end
  always @(negedge sck_v) if (cs_v === 1'b0 && idx_v > 0) begin idx_v--; sdo_v = cur_v[idx_v]; end

  // Pin monitor for the one-shot instance, sampled mid-cycle.
  int ncyc = 0, cs_fall_t = 0, cs_rise_t = 0, first_fall_t = 0, last_rise_t = 0;
  int rise_cnt = 0, fall_cnt = 0, sck_bad = 0, cs_fall_cnt = 0, vcount_d = 0;
  bit got_first = 1'b0;
  logic prev_cs = 1'b1, prev_sck = 1'b1;

  always @(negedge clk) begin
    ncyc++;
    if (prev_cs === 1'b1 && cs_d === 1'b0) begin
      cs_fall_t = ncyc; rise_cnt = 0; fall_cnt = 0; got_first = 1'b0; cs_fall_cnt++;
    end
    if (prev_cs === 1'b0 && cs_d === 1'b1) cs_rise_t = ncyc;
    if (cs_d === 1'b0 && prev_sck === 1'b1 && sck_d === 1'b0) begin
      fall_cnt++;
      if (!got_first) begin first_fall_t = ncyc; got_first = 1'b1; end
    end
    if (cs_d === 1'b0 && prev_sck === 1'b0 && sck_d === 1'b1) begin
      rise_cnt++; last_rise_t = ncyc;
    end
    if (cs_d === 1'b1 && prev_cs === 1'b1 && sck_d !== prev_sck) sck_bad++;
    if (valid_d === 1'b1) vcount_d++;
    prev_cs  = cs_d;
    prev_sck = sck_d;
  end

  function automatic logic [7:0] field_12_5(input logic [31:0] w);
    return 8'((w >> 5) & 32'hFF);
  endfunction

  // Pulses start on the one-shot instance and counts cycles to valid, the
  // sampling edge being cycle 1.
  task automatic kick_d(output int lat);
    @(negedge clk); start_d = 1'b1;
    @(posedge clk); lat = 1; #1; start_d = 1'b0;
    while (valid_d !== 1'b1 && lat < 5000) begin @(posedge clk); lat++; #1; end
  endtask

  task automatic wait_idle_d(input string name);
    int n = 0;
    while (busy_d === 1'b1 && n < 2000) begin @(posedge clk); n++; #1; end
    total++;
    if (busy_d !== 1'b0) begin bad++; $display("FAIL %s busy=%b exp=0", name, busy_d); end
  endtask

  task automatic test_reset;
    rst_n_d = 1'b0; rst_n_c = 1'b0; rst_n_v = 1'b0;
    start_d = 1'b0; start_c = 1'b0; start_v = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({cs_d, sck_d, valid_d, busy_d} !== 4'b1100) begin
      bad++; $display("FAIL reset_pins_d cs/sck/valid/busy=%b exp=1100", {cs_d, sck_d, valid_d, busy_d});
    end
    total++;
    if (frame_d !== 16'h0 || data_d !== 8'h0) begin
      bad++; $display("FAIL reset_regs_d frame=%h data=%h exp=0", frame_d, data_d);
    end
    total++;
    if ({cs_c, sck_c, valid_c} !== 3'b110 || {cs_v, sck_v, valid_v} !== 3'b110) begin
      bad++; $display("FAIL reset_pins_cv c=%b v=%b exp=110", {cs_c, sck_c, valid_c}, {cs_v, sck_v, valid_v});
    end
    @(negedge clk); rst_n_d = 1'b1; rst_n_v = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_one_shot;
    int lat;
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      w = (i == 0) ? 32'h0B50 : ($urandom & 32'hFFFF);
      wq_d.push_back(w);
      kick_d(lat);
      total++;
      if (lat != 1 + 8 * (2 * 16 + 2)) begin bad++; $display("FAIL oneshot_latency got=%0d exp=%0d", lat, 1 + 8 * 34); end
      total++;
      if (frame_d !== w[15:0]) begin bad++; $display("FAIL oneshot_frame got=%h exp=%h", frame_d, w[15:0]); end
      total++;
      if (data_d !== field_12_5(w)) begin bad++; $display("FAIL oneshot_data got=%h exp=%h", data_d, field_12_5(w)); end
      @(negedge clk); #1;
      total++;
      if (rise_cnt != 16) begin bad++; $display("FAIL sck_rises got=%0d exp=16", rise_cnt); end
      total++;
      if (first_fall_t - cs_fall_t != 8) begin
        bad++; $display("FAIL cs_setup got=%0d exp=8", first_fall_t - cs_fall_t);
      end
      total++;
      if (cs_rise_t - last_rise_t < 8) begin
        bad++; $display("FAIL cs_hold got=%0d exp>=8", cs_rise_t - last_rise_t);
      end
      wait_idle_d("oneshot_idle");
    end
    total++;
    if (sck_bad != 0) begin bad++; $display("FAIL sck_quiet_cs_high got=%0d exp=0", sck_bad); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] w1, w2, w3;
    int lat, n, seen, t_first, fall0;
    bit busy_dropped;
    w1 = $urandom & 32'hFFFF; w2 = $urandom & 32'hFFFF; w3 = $urandom & 32'hFFFF;
    wq_d.push_back(w1); wq_d.push_back(w2); wq_d.push_back(w3);
    fall0 = cs_fall_cnt;
    @(negedge clk); start_d = 1'b1;
    @(negedge clk); start_d = 1'b0;
    for (int k = 0; k < 2; k++) begin
      repeat (20 + ($urandom % 30)) @(negedge clk);
      start_d = 1'b1;
      @(negedge clk); start_d = 1'b0;
    end
    n = 0; seen = 0; t_first = 0; busy_dropped = 1'b0;
    while (seen < 2 && n < 3000) begin
      @(posedge clk); n++; #1;
      if (busy_d !== 1'b1) busy_dropped = 1'b1;
      if (valid_d === 1'b1) begin
        lat = (seen == 0) ? 0 : n - t_first;
        if (seen == 0) t_first = n;
        total++;
        if (data_d !== field_12_5(seen == 0 ? w1 : w2) || frame_d !== (seen == 0 ? w1[15:0] : w2[15:0])) begin
          bad++; $display("FAIL b2b_frame%0d got=%h exp=%h", seen, frame_d, (seen == 0 ? w1[15:0] : w2[15:0]));
        end
        if (seen == 1) begin
          total++;
          if (lat != 528) begin bad++; $display("FAIL b2b_spacing got=%0d exp=528", lat); end
        end
        seen++;
      end
    end
    total++;
    if (seen != 2) begin bad++; $display("FAIL b2b_valid_count got=%0d exp=2", seen); end
    total++;
    if (busy_dropped) begin bad++; $display("FAIL b2b_busy got=0 exp=1 across both frames"); end
    wait_idle_d("b2b_idle");
    repeat (300) @(posedge clk);
    total++;
    if (cs_fall_cnt - fall0 != 2 || wq_d.size() != 1) begin
      bad++; $display("FAIL b2b_extra_frames got=%0d exp=2", cs_fall_cnt - fall0);
    end
    wq_d.delete();
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] wa, wb;
    int n, lat, v0;
    wa = $urandom & 32'hFFFF; wb = $urandom & 32'hFFFF;
    wq_d.push_back(wa); wq_d.push_back(wb);
    @(negedge clk); start_d = 1'b1;
    @(negedge clk); start_d = 1'b0;
    n = 0;
    while (!(cs_d === 1'b0 && fall_cnt >= 8) && n < 1000) begin @(posedge clk); n++; end
    repeat (3) @(posedge clk);
    #3;
    v0 = vcount_d;
    rst_n_d = 1'b0;
    #1;
    total++;
    if (cs_d !== 1'b1 || sck_d !== 1'b1) begin
      bad++; $display("FAIL async_abort cs=%b sck=%b exp=1 1", cs_d, sck_d);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n_d = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    total++;
    if (vcount_d != v0 || data_d !== 8'h0 || frame_d !== 16'h0) begin
      bad++; $display("FAIL abort_no_update valids=%0d data=%h exp=0 0", vcount_d - v0, data_d);
    end
    kick_d(lat);
    total++;
    if (data_d !== field_12_5(wb) || lat != 273) begin
      bad++; $display("FAIL post_reset_frame data=%h lat=%0d exp=%h 273", data_d, lat, field_12_5(wb));
    end
    wait_idle_d("post_reset_idle");
  endtask

  task automatic test_continuous;
    logic [7:0] vals [3];
    logic [31:0] ws [3];
    int n;
    vals[0] = 8'h00; vals[1] = 8'hFF; vals[2] = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      ws[i] = ($urandom & 32'hE01F) | (32'(vals[i]) << 5);
      wq_c.push_back(ws[i]);
    end
    @(negedge clk); rst_n_c = 1'b1;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      do begin @(posedge clk); n++; #1; end while (valid_c !== 1'b1 && n < 528 * (i + 1) + 100);
      total++;
      if (n != 528 * (i + 1)) begin bad++; $display("FAIL cont_period%0d got=%0d exp=%0d", i, n, 528 * (i + 1)); end
      total++;
      if (data_c !== vals[i] || frame_c !== ws[i][15:0]) begin
        bad++; $display("FAIL cont_data%0d got=%h exp=%h", i, data_c, vals[i]);
      end
    end
  endtask

  task automatic test_variant;
    logic [31:0] w;
    int lat, n;
    for (int i = 0; i < 3; i++) begin
      w = (i == 0) ? 32'hA5C : ($urandom & 32'hFFF);
      wq_v.push_back(w);
      @(negedge clk); start_v = 1'b1;
      @(posedge clk); lat = 1; #1; start_v = 1'b0;
      while (valid_v !== 1'b1 && lat < 500) begin @(posedge clk); lat++; #1; end
      total++;
      if (lat != 1 + 2 * 26) begin bad++; $display("FAIL variant_latency got=%0d exp=53", lat); end
      total++;
      if (frame_v !== w[11:0] || data_v !== w[11:0]) begin
        bad++; $display("FAIL variant_frame got=%h exp=%h", frame_v, w[11:0]);
      end
      n = 0;
      while (busy_v === 1'b1 && n < 100) begin @(posedge clk); n++; #1; end
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_back_to_back();
    test_reset_mid_frame();
    test_continuous();
    test_variant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
